// File: rtl/xor_check_monitor.sv
// rtl/xor_check_monitor.sv - monitors that a/b differ on every qualified sample, counts outcomes and raises a sticky alarm on a fail run
// Optional first-fail capture enabled by defining XOR_CHK_FIRST_FAIL_EN.
module xor_check_monitor #(
  parameter int CNT_W     = 8,
  parameter int RUN_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             a,
  input  logic             b,
  input  logic             clr,
  output logic             fail,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] run_len,
  output logic             alarm,
  output logic [1:0]       state
`ifdef XOR_CHK_FIRST_FAIL_EN
  ,
  output logic             first_fail_vld,
  output logic [CNT_W-1:0] first_fail_idx
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MONITOR = 2'd1,
    S_ALARM   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] RUN_LIM = RUN_LIMIT[CNT_W-1:0];

  state_t           state_q;
  state_t           state_d;
  logic             smp;
  logic             smp_fail;
  logic             smp_pass;
  logic [CNT_W-1:0] run_len_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // clr discards a coincident sample, so it masks the qualifier here
  assign smp      = en & ~clr;
  assign smp_fail = smp & ~(a ^ b);
  assign smp_pass = smp & (a ^ b);

  always_comb begin
    run_len_d = run_len;
    if (smp_fail) begin
      run_len_d = sat_inc(run_len);
    end else if (smp_pass) begin
      run_len_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = S_IDLE;
    end else if (smp) begin
      case (state_q)
        S_IDLE, S_MONITOR: begin
          // IDLE can go straight to ALARM when RUN_LIMIT is 1
          if (smp_fail && (run_len_d == RUN_LIM)) begin
            state_d = S_ALARM;
          end else begin
            state_d = S_MONITOR;
          end
        end
        S_ALARM: state_d = S_ALARM;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      alarm   <= 1'b0;
    end else begin
      state_q <= state_d;
      alarm   <= (state_d == S_ALARM);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      fail     <= 1'b0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      run_len  <= '0;
    end else begin
      fail    <= smp_fail;
      run_len <= run_len_d;
      if (smp_pass) begin
        pass_cnt <= sat_inc(pass_cnt);
      end
      if (smp_fail) begin
        fail_cnt <= sat_inc(fail_cnt);
      end
    end
  end

  assign state = state_q;

`ifdef XOR_CHK_FIRST_FAIL_EN
  logic [CNT_W-1:0] smp_idx;

  // smp_idx holds the zero-based index of the sample being taken this cycle
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      smp_idx        <= '0;
      first_fail_vld <= 1'b0;
      first_fail_idx <= '0;
    end else begin
      if (smp) begin
        smp_idx <= sat_inc(smp_idx);
      end
      if (smp_fail && !first_fail_vld) begin
        first_fail_vld <= 1'b1;
        first_fail_idx <= smp_idx;
      end
    end
  end
`endif

endmodule

// File: tb/tb_xor_check_monitor.sv
// tb/tb_xor_check_monitor.sv - directed self-checking bench for xor_check_monitor
module tb_xor_check_monitor;

  logic       clk;
  logic       rst;
  logic       en;
  logic       a;
  logic       b;
  logic       clr;
  logic       fail;
  logic [7:0] pass_cnt;
  logic [7:0] fail_cnt;
  logic [7:0] run_len;
  logic       alarm;
  logic [1:0] state;
  logic       r1_fail;
  logic [7:0] r1_pass_cnt;
  logic [7:0] r1_fail_cnt;
  logic [7:0] r1_run_len;
  logic       r1_alarm;
  logic [1:0] r1_state;
`ifdef XOR_CHK_FIRST_FAIL_EN
  logic       ff_vld;
  logic [7:0] ff_idx;
  logic       r1_ff_vld;
  logic [7:0] r1_ff_idx;
`endif

  int checks = 0;
  int errors = 0;
  int max_run;

  xor_check_monitor #(.CNT_W(8), .RUN_LIMIT(3)) u_dut (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .clr(clr),
    .fail(fail), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .run_len(run_len),
    .alarm(alarm), .state(state)
`ifdef XOR_CHK_FIRST_FAIL_EN
    , .first_fail_vld(ff_vld), .first_fail_idx(ff_idx)
`endif
  );

  xor_check_monitor #(.CNT_W(8), .RUN_LIMIT(1)) u_dut_r1 (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .clr(clr),
    .fail(r1_fail), .pass_cnt(r1_pass_cnt), .fail_cnt(r1_fail_cnt), .run_len(r1_run_len),
    .alarm(r1_alarm), .state(r1_state)
`ifdef XOR_CHK_FIRST_FAIL_EN
    , .first_fail_vld(r1_ff_vld), .first_fail_idx(r1_ff_idx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic s_rst, input logic s_en, input logic s_a, input logic s_b, input logic s_clr);
    rst = s_rst;
    en  = s_en;
    a   = s_a;
    b   = s_b;
    clr = s_clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_fail"},  32'(fail),     0);
    check({tag, "_pass"},  32'(pass_cnt), 0);
    check({tag, "_fcnt"},  32'(fail_cnt), 0);
    check({tag, "_run"},   32'(run_len),  0);
    check({tag, "_alarm"}, 32'(alarm),    0);
    check({tag, "_state"}, 32'(state),    0);
  endtask

  logic [1:0] seq [10];

  initial begin
    rst = 1'b1; en = 1'b0; a = 1'b0; b = 1'b0; clr = 1'b0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check_zero("reset");

    // 00,01,11,11,10,11,01,10,10,10 -> runs 1,0,1,2,0,1,0,0,0,0
    seq = '{2'b00, 2'b01, 2'b11, 2'b11, 2'b10, 2'b11, 2'b01, 2'b10, 2'b10, 2'b10};
    max_run = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 1, seq[i][1], seq[i][0], 0);
      if (int'(run_len) > max_run) max_run = int'(run_len);
      if (i == 0) begin
        check("seq_fail0", 32'(fail), 1);
        check("seq_state0", 32'(state), 1);
        check("r1_first_fail_alarm_state", 32'(r1_state), 2);
        check("r1_first_fail_alarm", 32'(r1_alarm), 1);
      end
      if (i == 1) check("seq_fail1", 32'(fail), 0);
      if (i == 3) check("seq_run3", 32'(run_len), 2);
    end
    check("seq_fcnt", 32'(fail_cnt), 4);
    check("seq_pcnt", 32'(pass_cnt), 6);
    check("seq_maxrun", 32'(max_run), 2);
    check("seq_alarm", 32'(alarm), 0);
    check("seq_state", 32'(state), 1);
    check("r1_seq_alarm_sticky", 32'(r1_alarm), 1);

    step(0, 0, 0, 0, 1);
    check_zero("clr");

    // three consecutive fails reach RUN_LIMIT=3
    step(0, 1, 1, 1, 0);
    step(0, 1, 0, 0, 0);
    check("run2_alarm", 32'(alarm), 0);
    check("run2_state", 32'(state), 1);
    step(0, 1, 1, 1, 0);
    check("run3_len", 32'(run_len), 3);
    check("run3_state", 32'(state), 2);
    check("run3_alarm", 32'(alarm), 1);
    step(0, 1, 0, 1, 0);
    check("alarm_pass_run", 32'(run_len), 0);
    check("alarm_pass_alarm", 32'(alarm), 1);
    check("alarm_pass_pcnt", 32'(pass_cnt), 1);
    check("alarm_pass_fail", 32'(fail), 0);

    // clr with a coincident failing sample while in ALARM
    step(0, 1, 1, 1, 1);
    check_zero("clr_alarm");
    step(0, 1, 1, 0, 0);
    check("post_clr_pcnt", 32'(pass_cnt), 1);
    check("post_clr_fcnt", 32'(fail_cnt), 0);
    check("post_clr_state", 32'(state), 1);

    // en=0 gap between two failing samples
    step(0, 0, 0, 0, 1);
    step(0, 1, 1, 1, 0);
    check("gap_run_a", 32'(run_len), 1);
    check("gap_fail_a", 32'(fail), 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 1, 0);
      check("gap_fail_low", 32'(fail), 0);
      check("gap_run_hold", 32'(run_len), 1);
    end
    step(0, 1, 0, 0, 0);
    check("gap_run_b", 32'(run_len), 2);
    check("gap_fail_b", 32'(fail), 1);
    check("gap_fcnt", 32'(fail_cnt), 2);

    // rst wins over clr and a coincident sample
    step(1, 1, 1, 1, 1);
    check_zero("rst_prio");

    // saturation at 255
    for (int i = 0; i < 300; i++) begin
      step(0, 1, i[0], i[0], 0);
      if (i == 253) check("sat_fcnt_254", 32'(fail_cnt), 254);
    end
    check("sat_fcnt", 32'(fail_cnt), 255);
    check("sat_run", 32'(run_len), 255);
    check("sat_pcnt", 32'(pass_cnt), 0);
    check("sat_state", 32'(state), 2);
    check("r1_sat_fcnt", 32'(r1_fail_cnt), 255);

    // rst out of ALARM discards history
    step(1, 0, 0, 0, 0);
    check_zero("rst_alarm");
    step(0, 1, 0, 1, 0);
    check("first_after_rst_state", 32'(state), 1);
    check("first_after_rst_pcnt", 32'(pass_cnt), 1);
    check("first_after_rst_fcnt", 32'(fail_cnt), 0);

`ifdef XOR_CHK_FIRST_FAIL_EN
    step(1, 0, 0, 0, 0);
    check("ff_rst_vld", 32'(ff_vld), 0);
    check("ff_rst_idx", 32'(ff_idx), 0);
    step(0, 1, 0, 1, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 0, 1, 0);
    check("ff_pre_vld", 32'(ff_vld), 0);
    step(0, 1, 1, 1, 0);
    check("ff_idx", 32'(ff_idx), 3);
    check("ff_vld", 32'(ff_vld), 1);
    check("ff_with_fail", 32'(fail), 1);
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    check("ff_idx_sticky", 32'(ff_idx), 3);
    check("ff_vld_sticky", 32'(ff_vld), 1);
    step(1, 0, 0, 0, 0);
    check("ff_rst2_vld", 32'(ff_vld), 0);
    check("ff_rst2_idx", 32'(ff_idx), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
